// File: rtl/fpu16_issue_ctrl_pkg.sv
// fpu16_issue_ctrl_pkg: shared FP16 FPU types and issue-controller definitions
package fpu16_issue_ctrl_pkg;
  typedef logic [15:0] fp16_t;
  typedef enum logic [1:0] {FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV} fpuOp_t;
  typedef logic [3:0] condCode_t;
  typedef logic [4:0] statusFlag_t;
  typedef logic [2:0] fpuComp_t;
  typedef enum logic [1:0] {ISS_IDLE, ISS_EXEC, ISS_RESP} fpuIssueState_t;
  localparam fp16_t FPU_QNAN = 16'h7E00;
  localparam statusFlag_t FLAG_NV = 5'b10000;
  typedef struct packed {
    fp16_t       data;
    condCode_t   cc;
    statusFlag_t flags;
    fpuComp_t    comps;
    logic        timeout;
  } fpuRsp_t;
endpackage

// File: rtl/fpu16_issue_ctrl.sv
// fpu16_issue_ctrl: issues commands to the FP16 FPU, waits op latency with a MUL watchdog, returns tagged results and sticky flags
module fpu16_issue_ctrl
  import fpu16_issue_ctrl_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  fpuOp_t           cmd_op,
  input  fp16_t            cmd_a,
  input  fp16_t            cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output fp16_t            fpuIn1,
  output fp16_t            fpuIn2,
  output fpuOp_t           op,
  output logic             start,
  input  fp16_t            fpuOut,
  input  condCode_t        condCodes,
  input  statusFlag_t      statusFlags,
  input  fpuComp_t         comps,
  input  logic             mulDone,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [3:0]       rsp_cc,
  output logic [4:0]       rsp_flags,
  output logic [2:0]       rsp_comps,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  input  logic             flags_clr,
  output logic [4:0]       flags_acc
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  fpuIssueState_t state, state_n;
  fpuRsp_t rsp, rsp_n, fpu_rsp, div_rsp, tmo_rsp;
  logic [CW-1:0] wait_cnt, wait_n;
  logic [TAG_W-1:0] tag;
  logic accept;
  assign cmd_ready = state == ISS_IDLE && !reset;
  assign accept = cmd_valid && cmd_ready;
  assign rsp_valid = state == ISS_RESP;
  assign {rsp_data, rsp_cc, rsp_flags, rsp_comps, rsp_timeout} = rsp;
  assign rsp_tag = tag;
  assign fpu_rsp = '{data: fpuOut, cc: condCodes, flags: statusFlags, comps: comps, timeout: 1'b0};
  assign div_rsp = '{data: FPU_QNAN, cc: '0, flags: FLAG_NV, comps: '0, timeout: 1'b0};
  assign tmo_rsp = '{data: FPU_QNAN, cc: '0, flags: '0, comps: '0, timeout: 1'b1};
  always_comb begin
    state_n = state;
    rsp_n = rsp;
    wait_n = wait_cnt;
    case (state)
      ISS_IDLE: begin
        state_n = accept ? ISS_EXEC : ISS_IDLE;
        wait_n = '0;
      end
      ISS_EXEC:
        if (op != FPU_MUL) begin
          state_n = ISS_RESP;
          rsp_n = op == FPU_DIV ? div_rsp : fpu_rsp;
        end else if (!start && mulDone) begin
          state_n = ISS_RESP;
          rsp_n = fpu_rsp;
        end else if (wait_cnt == WAIT_LAST) begin
          state_n = ISS_RESP;
          rsp_n = tmo_rsp;
        end else
          wait_n = wait_cnt + CW'(wait_cnt != '1);
      ISS_RESP: state_n = rsp_ready ? ISS_IDLE : ISS_RESP;
      default: state_n = ISS_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset)
      state <= ISS_IDLE;
    else
      state <= state_n;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      fpuIn1 <= '0;
      fpuIn2 <= '0;
      op <= FPU_ADD;
      tag <= '0;
      start <= 1'b0;
      wait_cnt <= '0;
      rsp <= '0;
      flags_acc <= '0;
    end else begin
      if (accept) begin
        fpuIn1 <= cmd_a;
        fpuIn2 <= cmd_b;
        op <= cmd_op;
        tag <= cmd_tag;
      end
      start <= accept && cmd_op == FPU_MUL;
      wait_cnt <= wait_n;
      rsp <= rsp_n;
      flags_acc <= (flags_clr ? '0 : flags_acc) | (rsp_valid && rsp_ready ? rsp.flags : '0);
    end
endmodule

// File: doc/fpu16_issue_ctrl.md
Name: fpu16_issue_ctrl

Overview:
- Requester-side controller for the FP16 FPU.
- Accepts commands from the integer pipeline over a valid/ready channel and drives operands, op and start into the FPU.
- Waits the op-dependent latency: ADD/SUB are single-cycle; MUL waits for the multiplier's done, bounded by a watchdog.
- Returns a tagged result over a valid/ready channel and accumulates sticky IEEE status flags for the CSR file.

Parameters:
- TAG_W, 4: width of the command/response tag.
- TIMEOUT, 16: maximum EXEC cycles spent waiting for mulDone before abort.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  fpuOp_t(2)  requested operation
- cmd_a, cmd_b  in  fp16_t(16)  operands
- cmd_tag  in  TAG_W  caller tag
- fpuIn1, fpuIn2  out  fp16_t(16)  registered operands to the FPU
- op  out  fpuOp_t(2)  registered op to the FPU
- start  out  1  one-cycle MUL start pulse
- fpuOut  in  fp16_t(16)  FPU result
- condCodes  in  condCode_t(4)  FPU condition codes
- statusFlags  in  statusFlag_t(5)  {NV,DZ,OF,UF,NX}
- comps  in  fpuComp_t(3)  {lt,eq,gt}
- mulDone  in  1  multiplier done (level or pulse)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  16  result
- rsp_cc  out  4  captured condCodes
- rsp_flags  out  5  captured statusFlags
- rsp_comps  out  3  captured comps
- rsp_tag  out  TAG_W  tag of the command
- rsp_timeout  out  1  MUL aborted by watchdog
- flags_clr  in  1  clear sticky flags
- flags_acc  out  5  sticky OR of accepted rsp_flags

Behaviour:
- Reset values: every register is 0, state is IDLE, op is FPU_ADD, start is 0, rsp_valid is 0, flags_acc is 0.
- cmd_ready = (state==IDLE) && !reset.
- Reset mid-operation aborts immediately; no response is produced. The FPU is re-synchronised because start is 0.
- States:
  - IDLE: on cmd_valid&&cmd_ready, register cmd_a/cmd_b/cmd_op into fpuIn1/fpuIn2/op and latch the tag; clear wait_cnt; go to EXEC.
    - start is set at the same edge only when cmd_op==FPU_MUL.
  - EXEC, cycle 0 (operands stable):
    - ADD/SUB: capture fpuOut/condCodes/statusFlags/comps; go to RESP. Accept-to-rsp_valid latency is 2 edges.
    - DIV: the divider is unimplemented. Load rsp_data=16'h7E00 (FPU_QNAN), rsp_flags=5'b10000 (NV), cc=0, comps=0; go to RESP.
    - MUL: start is high for this cycle only and deasserts at the next edge. mulDone is ignored in cycle 0 to avoid stale done.
  - EXEC, MUL cycles >=1:
    - If mulDone, capture outputs and go to RESP.
    - Else increment wait_cnt.
    - When wait_cnt reaches TIMEOUT-1 without done, go to RESP with rsp_timeout=1, rsp_data=16'h7E00 and flags=0.
    - mulDone in the same cycle as the timeout wins: normal result, timeout=0.
  - RESP:
    - rsp_valid=1; all rsp_* are held stable until rsp_ready.
    - On handshake go to IDLE.
    - No bypass: minimum issue interval is 3 cycles with rsp_ready tied high.
- fpuIn1/fpuIn2/op hold their last values outside EXEC.
- Sticky flags, updated at each edge:
  - flags_acc <= (flags_clr ? 0 : flags_acc) | (rsp_valid&&rsp_ready ? rsp_flags : 0).
  - A clear and an accept in the same cycle leave only the new flags.
- wait_cnt width is $clog2(TIMEOUT+1) and saturates; it never wraps.

Decomposition:
- Add to constants.sv:
  - fpuIssueState_t enum {ISS_IDLE, ISS_EXEC, ISS_RESP}
  - FPU_QNAN = 16'h7E00
  - fpuRsp_t packed struct {data, cc, flags, comps, timeout}
- Reuse the existing fp16_t, fpuOp_t, condCode_t, statusFlag_t and fpuComp_t.
- No sub-module: the FSM, watchdog counter and response register are a single module.

Test Plan:
- ADD 3C00+4000, tag 5, rsp_ready=1 -> rsp_valid 2 cycles after accept; rsp_data=4200, rsp_tag=5, flags=0; start never asserts.
- MUL 4000*4200, bench model asserts mulDone 4 cycles after start -> start is a single 1-cycle pulse; rsp_data=4600 one cycle after done; cmd_ready low throughout.
- MUL with no mulDone, TIMEOUT=8 -> rsp_timeout=1 and rsp_data=7E00 after 8 EXEC cycles. Repeat with done on cycle 7 -> normal result, timeout=0.
- DIV 3C00/0000 -> rsp_data=7E00, rsp_flags=10000, latency 2; flags_acc becomes 10000 after the handshake.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, second command not accepted until 1 cycle after the handshake.
- flags_clr asserted in the same cycle as a handshake carrying 00001 -> flags_acc=00001. Assert reset during MUL EXEC -> all outputs return to their reset values asynchronously, and no response appears afterward.
